serv_axil_sram_slave: RTL and testbench

SERV_AXIL_SRAM_SLAVE -- requirements
Module: serv_axil_sram_slave

---
 rtl/serv_axil_sram_slave.sv | 107 ++++++++++
 tb/tb_serv_axil_sram_slave.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/serv_axil_sram_slave.sv
// serv_axil_sram_slave: AXI4-Lite word-addressed SRAM slave, one transaction at a time, writes before reads
module serv_axil_sram_slave #(
  parameter int AW = 12,
  parameter int MEMSIZE = 4096,
  parameter MEMFILE = ""
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] i_awaddr,
  input  logic          i_awvalid,
  output logic          o_awready,
  input  logic [31:0]   i_wdata,
  input  logic [3:0]    i_wstrb,
  input  logic          i_wvalid,
  output logic          o_wready,
  output logic [1:0]    o_bresp,
  output logic          o_bvalid,
  input  logic          i_bready,
  input  logic [AW-1:0] i_araddr,
  input  logic          i_arvalid,
  output logic          o_arready,
  output logic [31:0]   o_rdata,
  output logic [1:0]    o_rresp,
  output logic          o_rlast,
  output logic          o_rvalid,
  input  logic          i_rready
);
  localparam int IW = $clog2(MEMSIZE / 4);
  localparam logic [31:0] MSZ = 32'(MEMSIZE);
  typedef enum logic [1:0] {IDLE, WRESP, RWAIT, RDATA} state_t;
  state_t state;
  logic aw_held, w_held, ar_oor;
  logic [AW-1:0] awaddr_q;
  logic [31:0] wdata_q, rd_q;
  logic [3:0] wstrb_q;
  logic [31:0] mem [MEMSIZE/4];
  logic idle, aw_ok, w_ok, wr_go, wr_oor, ar_go;
  logic [AW-1:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0] wr_strb;
  assign idle = state == IDLE;
  assign o_awready = rst_n && idle && !aw_held;
  assign o_wready = rst_n && idle && !w_held;
  assign o_arready = rst_n && idle && !aw_held && !w_held && !i_awvalid && !i_wvalid;
  assign o_bvalid = state == WRESP;
  assign o_rvalid = state == RDATA;
  assign o_rlast = 1'b1;
  assign aw_ok = aw_held || (i_awvalid && o_awready);
  assign w_ok = w_held || (i_wvalid && o_wready);
  assign wr_go = idle && aw_ok && w_ok;
  assign wr_addr = aw_held ? awaddr_q : i_awaddr;
  assign wr_data = w_held ? wdata_q : i_wdata;
  assign wr_strb = w_held ? wstrb_q : i_wstrb;
  assign wr_oor = 32'(wr_addr) >= MSZ;
  assign ar_go = i_arvalid && o_arready;
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++)
      if (wr_go && !wr_oor && wr_strb[k]) mem[wr_addr[IW+1:2]][8*k +: 8] <= wr_data[8*k +: 8];
    if (ar_go) rd_q <= mem[i_araddr[IW+1:2]];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      aw_held <= 1'b0;
      w_held <= 1'b0;
      awaddr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      ar_oor <= 1'b0;
      o_bresp <= 2'b00;
      o_rresp <= 2'b00;
      o_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (wr_go) begin
            state <= WRESP;
            aw_held <= 1'b0;
            w_held <= 1'b0;
            o_bresp <= wr_oor ? 2'b10 : 2'b00;
          end else begin
            if (i_awvalid && o_awready) begin
              aw_held <= 1'b1;
              awaddr_q <= i_awaddr;
            end
            if (i_wvalid && o_wready) begin
              w_held <= 1'b1;
              wdata_q <= i_wdata;
              wstrb_q <= i_wstrb;
            end
            if (ar_go) begin
              state <= RWAIT;
              ar_oor <= 32'(i_araddr) >= MSZ;
            end
          end
        end
        WRESP: state <= i_bready ? IDLE : WRESP;
        RWAIT: begin
          state <= RDATA;
          o_rdata <= ar_oor ? 32'h0 : rd_q;
          o_rresp <= ar_oor ? 2'b10 : 2'b00;
        end
        RDATA: state <= i_rready ? IDLE : RDATA;
      endcase
    end
  end
endmodule

// File: tb/tb_serv_axil_sram_slave.sv
// tb_serv_axil_sram_slave: directed checks of handshakes, byte strobes, range errors, priority and reset
module tb_serv_axil_sram_slave;
  logic clk = 0, rst_n = 0;
  logic [11:0] awaddr = 0, araddr = 0;
  logic awvalid = 0, wvalid = 0, bready = 1, arvalid = 0, rready = 1;
  logic [31:0] wdata = 0;
  logic [3:0] wstrb = 0;
  logic awready, wready, bvalid, arready, rlast, rvalid;
  logic [1:0] bresp, rresp;
  logic [31:0] rdata;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  serv_axil_sram_slave #(.AW(12), .MEMSIZE(2048)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_awaddr(awaddr), .i_awvalid(awvalid), .o_awready(awready),
    .i_wdata(wdata), .i_wstrb(wstrb), .i_wvalid(wvalid), .o_wready(wready),
    .o_bresp(bresp), .o_bvalid(bvalid), .i_bready(bready),
    .i_araddr(araddr), .i_arvalid(arvalid), .o_arready(arready),
    .o_rdata(rdata), .o_rresp(rresp), .o_rlast(rlast), .o_rvalid(rvalid), .i_rready(rready)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s, input logic [1:0] er);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
    @(negedge clk);
    chk("awready", awready, 1);
    chk("wready", wready, 1);
    tick;
    awvalid = 0; wvalid = 0;
    @(negedge clk);
    chk("bvalid", bvalid, 1);
    chk("bresp", bresp, er);
    tick;
    chk("bvalid_done", bvalid, 0);
  endtask
  task automatic rd(input logic [11:0] a, input logic [31:0] ed, input logic [1:0] er);
    araddr = a; arvalid = 1;
    @(negedge clk);
    chk("arready", arready, 1);
    tick;
    arvalid = 0;
    @(negedge clk);
    chk("rvalid_n1", rvalid, 0);
    tick;
    @(negedge clk);
    chk("rvalid_n2", rvalid, 1);
    chk("rlast", rlast, 1);
    chk("rdata", rdata, ed);
    chk("rresp", rresp, er);
    tick;
    chk("rvalid_done", rvalid, 0);
  endtask
  initial begin
    #3;
    chk("rst_awready", awready, 0);
    chk("rst_wready", wready, 0);
    chk("rst_arready", arready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    tick; tick;
    rst_n = 1;
    @(negedge clk);
    chk("idle_awready", awready, 1);
    chk("idle_arready", arready, 1);
    tick;
    wr(12'h010, 32'hDEADBEEF, 4'hF, 2'b00);
    rd(12'h010, 32'hDEADBEEF, 2'b00);
    // W three cycles ahead of AW, partial strobes
    wdata = 32'h11223344; wstrb = 4'b0101; wvalid = 1;
    @(negedge clk);
    chk("w_first_wready", wready, 1);
    tick;
    wvalid = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("wheld_awready", awready, 1);
      chk("wheld_wready", wready, 0);
      chk("wheld_arready", arready, 0);
      tick;
    end
    awaddr = 12'h010; awvalid = 1;
    @(negedge clk);
    chk("aw_late_awready", awready, 1);
    chk("aw_late_wready", wready, 0);
    tick;
    awvalid = 0;
    @(negedge clk);
    chk("split_bvalid", bvalid, 1);
    chk("split_bresp", bresp, 0);
    tick;
    rd(12'h010, 32'hDE22BE44, 2'b00);
    // out-of-range write must not alias onto the top word
    wr(12'h7FC, 32'h55AA55AA, 4'hF, 2'b00);
    wr(12'hFFC, 32'hFFFFFFFF, 4'hF, 2'b10);
    rd(12'h7FC, 32'h55AA55AA, 2'b00);
    rd(12'h800, 32'h0, 2'b10);
    // simultaneous write and read: write wins
    awaddr = 12'h020; wdata = 32'hCAFEF00D; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    araddr = 12'h020; arvalid = 1;
    @(negedge clk);
    chk("prio_arready", arready, 0);
    chk("prio_awready", awready, 1);
    tick;
    awvalid = 0; wvalid = 0;
    @(negedge clk);
    chk("prio_bvalid", bvalid, 1);
    chk("prio_arready_b", arready, 0);
    tick;
    @(negedge clk);
    chk("prio_arready_after", arready, 1);
    tick;
    arvalid = 0;
    tick;
    @(negedge clk);
    chk("prio_rvalid", rvalid, 1);
    chk("prio_rdata", rdata, 32'hCAFEF00D);
    tick;
    // backpressured B with an error response
    bready = 0;
    awaddr = 12'h900; wdata = 32'h01020304; awvalid = 1; wvalid = 1;
    tick;
    awvalid = 0; wvalid = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_bvalid", bvalid, 1);
      chk("bp_bresp", bresp, 2'b10);
      chk("bp_awready", awready, 0);
      tick;
    end
    bready = 1;
    @(negedge clk);
    chk("bp_release", bvalid, 1);
    tick;
    chk("bp_done", bvalid, 0);
    // reset while R is pending
    rready = 0; araddr = 12'h010; arvalid = 1;
    tick;
    arvalid = 0;
    tick;
    @(negedge clk);
    chk("rr_rvalid", rvalid, 1);
    chk("rr_rdata", rdata, 32'hDE22BE44);
    #2 rst_n = 0;
    #1;
    chk("rr_rvalid_rst", rvalid, 0);
    chk("rr_rdata_rst", rdata, 0);
    chk("rr_arready_rst", arready, 0);
    tick; tick;
    rst_n = 1; rready = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rr_no_beat", rvalid, 0);
      tick;
    end
    rd(12'h010, 32'hDE22BE44, 2'b00);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
